multi_actor_trigger: RTL
========================

// Module: multi_actor_trigger
// PURPOSE
//  Parametrised successor of the single-actor trigger. Drives the ap_start of NUM_ACTORS actors, one per-actor FSM each.
//  Computes the all-sleep / all-sync aggregates internally and adds a per-run actor enable mask, a sleep-hold debounce,
//  wake-on-enqueue from SLEEP and a sync-round counter. Sits between the kernel control interface and the actor instances.
// PARAMETERS
//  NUM_ACTORS     4   number of actors controlled (>=1)
//  RET_W          32  width of each actor return code
//  EXECUTED_CODE  1   return value meaning "actor executed"
//  SLEEP_HOLD     2   cycles all enabled actors must stay in SLEEP before sync starts (>=1)
//  CNT_W          16  width of the sync-round counter
// PORTS
//  ap_clk            in   1               clock
//  ap_rst_n          in   1               asynchronous, active-low reset
//  ap_start          in   1               start a run (sampled only while ap_idle)
//  ap_done           out  1               run complete, one-cycle pulse
//  ap_ready          out  1               equal to ap_done
//  ap_idle           out  1               no run in progress
//  actor_en          in   NUM_ACTORS      actors taking part in the run, latched on accepted ap_start
//  external_enqueue  in   NUM_ACTORS      per-actor external buffer enqueue seen
//  actor_return      in   NUM_ACTORS*RET_W  return code, actor i at [i*RET_W +: RET_W]
//  actor_done        in   NUM_ACTORS      per-actor ap_done
//  actor_ready       in   NUM_ACTORS      per-actor ap_ready (status only, unused by the FSM)
//  actor_idle        in   NUM_ACTORS      per-actor ap_idle (status only)
//  actor_start       out  NUM_ACTORS      per-actor ap_start
//  sleep_vec         out  NUM_ACTORS      actor i is in SLEEP
//  sync_rounds       out  CNT_W           sync rounds completed in the current/last run (saturating)
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - All actor FSMs go to IDLE; en_mask=0; hold counter=0; sync_rounds=0.
//   - ap_idle=1; every other output is 0.
//  Run start: ap_start while ap_idle:
//   - latches en_mask=actor_en and clears sync_rounds.
//   - Enabled actors enter LAUNCH next cycle; ap_idle drops that cycle.
//  Disabled actors stay IDLE. In every aggregate they count as sleeping, synced and sync-waiting.
//  Per-actor FSM, for enabled actor i (exec = actor_return[i]==EXECUTED_CODE):
//   - IDLE: -> LAUNCH on accepted start.
//   - LAUNCH (1 cycle, actor_start[i]=1): done&(exec|enq) -> LAUNCH; done&!exec&!enq -> SLEEP; !done -> CHECK.
//   - CHECK: same as LAUNCH, except !done -> CHECK.
//   - SLEEP: enq -> LAUNCH (wake; the hold counter clears). Else, once all_sleep has held SLEEP_HOLD consecutive
//     cycles -> SYNC_LAUNCH; every enabled actor moves together.
//   - SYNC_LAUNCH (actor_start[i]=1): done -> SYNC_EXEC if exec, else SYNC_WAIT; !done -> SYNC_CHECK.
//   - SYNC_CHECK: done -> SYNC_EXEC/SYNC_WAIT as above; else stay.
//   - SYNC_EXEC, SYNC_WAIT: hold until all_sync.
//  Sync resolution, when all_sync:
//   - If all_sync_wait: all actors -> IDLE and ap_done=ap_ready=1 for that one cycle; ap_idle=1 next cycle.
//   - Else: all actors -> SYNC_LAUNCH and sync_rounds += 1, saturating at 2^CNT_W-1.
//  external_enqueue is ignored in every SYNC_* state.
//  Aggregates, combinational over enabled actors:
//   - all_sleep = all in SLEEP.
//   - all_sync = all in SYNC_EXEC|SYNC_WAIT.
//   - all_sync_wait = all in SYNC_WAIT.
//  ap_done depends only on registered state (no input-to-output path).
//  actor_start depends only on registered state.
//  ap_start during a run is ignored.
//  en_mask==0: the first run cycle already satisfies all_sync_wait, so ap_done pulses the cycle after start.
//  Simultaneous enq and hold expiry in SLEEP: the wake wins for that actor. all_sleep falls, so no actor enters sync.
//  Reset mid-run: all FSMs go to IDLE immediately and actor_start drops asynchronously; no ap_done is produced.
// TESTING
//  1. N=4, all enabled, each actor returns !EXECUTED on its first done (1-cycle latency):
//     -> SLEEP; after 2 hold cycles all actors go to SYNC_LAUNCH; all return !exec -> ap_done 1 pulse, sync_rounds=0.
//  2. actor_en=4'b0101, enabled actors run as in test 1:
//     -> actor_start[1] and actor_start[3] never rise; ap_done pulses; ap_idle=1 on the next cycle.
//  3. Actor 2 returns EXECUTED in the first sync round, others !exec:
//     -> second SYNC_LAUNCH for all, sync_rounds=1; all !exec -> ap_done.
//  4. Actor 0 in SLEEP, external_enqueue[0]=1 in the hold-expiry cycle:
//     -> actor 0 goes to LAUNCH, no sync entered, hold counter restarts.
//  5. actor_en=0, pulse ap_start -> ap_done on the next cycle; actor_start stays 0.
//  6. Assert ap_rst_n=0 while in SYNC_CHECK -> actor_start=0 at once; ap_idle=1; ap_done never pulses.

Source files
------------

// File: rtl/multi_actor_trigger.sv
// Drives the ap_start handshake of NUM_ACTORS actors, each with its own FSM, and
// coordinates sleep-hold debounce, wake-on-enqueue and repeated sync rounds.
module multi_actor_trigger #(
    parameter int NUM_ACTORS    = 4,
    parameter int RET_W         = 32,
    parameter int EXECUTED_CODE = 1,
    parameter int SLEEP_HOLD    = 2,
    parameter int CNT_W         = 16
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic                        ap_start,
    output logic                        ap_done,
    output logic                        ap_ready,
    output logic                        ap_idle,
    input  logic [NUM_ACTORS-1:0]       actor_en,
    input  logic [NUM_ACTORS-1:0]       external_enqueue,
    input  logic [NUM_ACTORS*RET_W-1:0] actor_return,
    input  logic [NUM_ACTORS-1:0]       actor_done,
    input  logic [NUM_ACTORS-1:0]       actor_ready,
    input  logic [NUM_ACTORS-1:0]       actor_idle,
    output logic [NUM_ACTORS-1:0]       actor_start,
    output logic [NUM_ACTORS-1:0]       sleep_vec,
    output logic [CNT_W-1:0]            sync_rounds
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_CHECK,
        S_SLEEP,
        S_SYNC_LAUNCH,
        S_SYNC_CHECK,
        S_SYNC_EXEC,
        S_SYNC_WAIT
    } actor_state_e;

    localparam int               HOLD_W    = $clog2(SLEEP_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SLEEP_HOLD - 1);
    localparam logic [RET_W-1:0]  EXEC_VAL  = RET_W'(EXECUTED_CODE);

    actor_state_e            state_q [NUM_ACTORS];
    actor_state_e            state_d [NUM_ACTORS];
    logic [NUM_ACTORS-1:0]   en_mask_q, en_mask_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic [CNT_W-1:0]        rounds_q, rounds_d;
    logic                    run_q, run_d;

    logic [NUM_ACTORS-1:0]   exec_vec;
    logic                    all_sleep, all_sync, all_sync_wait;
    logic                    start_acc, wake_any, hold_expire, sync_go;
    logic                    unused_status;

    assign unused_status = ^{actor_ready, actor_idle};

    // Disabled actors never leave IDLE, so they are simply masked out of every aggregate.
    always_comb begin
        all_sleep     = 1'b1;
        all_sync      = 1'b1;
        all_sync_wait = 1'b1;
        exec_vec      = '0;
        for (int i = 0; i < NUM_ACTORS; i++) begin
            exec_vec[i] = (actor_return[i*RET_W +: RET_W] == EXEC_VAL);
            if (en_mask_q[i]) begin
                if (state_q[i] != S_SLEEP) all_sleep = 1'b0;
                if (state_q[i] != S_SYNC_EXEC && state_q[i] != S_SYNC_WAIT) all_sync = 1'b0;
                if (state_q[i] != S_SYNC_WAIT) all_sync_wait = 1'b0;
            end
        end
    end

    assign start_acc   = ap_start & ~run_q;
    assign wake_any    = |(external_enqueue & en_mask_q);
    assign hold_expire = run_q & all_sleep & (hold_q == HOLD_LAST);
    assign sync_go     = hold_expire & ~wake_any;

    assign ap_done  = run_q & all_sync_wait;
    assign ap_ready = ap_done;
    assign ap_idle  = ~run_q;

    always_comb begin
        run_d     = run_q;
        en_mask_d = en_mask_q;
        rounds_d  = rounds_q;
        hold_d    = '0;
        if (start_acc) begin
            run_d     = 1'b1;
            en_mask_d = actor_en;
            rounds_d  = '0;
        end else if (ap_done) begin
            run_d = 1'b0;
        end else if (run_q && all_sync && rounds_q != '1) begin
            rounds_d = rounds_q + CNT_W'(1);
        end
        if (run_q && all_sleep && !wake_any && !hold_expire) begin
            hold_d = hold_q + HOLD_W'(1);
        end
    end

    // A wake on any enabled actor cancels the pending sync entry for the whole group.
    always_comb begin
        for (int i = 0; i < NUM_ACTORS; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                S_IDLE: begin
                    if (start_acc && actor_en[i]) state_d[i] = S_LAUNCH;
                end
                S_LAUNCH, S_CHECK: begin
                    if (actor_done[i]) begin
                        state_d[i] = (exec_vec[i] || external_enqueue[i]) ? S_LAUNCH : S_SLEEP;
                    end else begin
                        state_d[i] = S_CHECK;
                    end
                end
                S_SLEEP: begin
                    if (external_enqueue[i]) state_d[i] = S_LAUNCH;
                    else if (sync_go)        state_d[i] = S_SYNC_LAUNCH;
                end
                S_SYNC_LAUNCH, S_SYNC_CHECK: begin
                    if (actor_done[i]) state_d[i] = exec_vec[i] ? S_SYNC_EXEC : S_SYNC_WAIT;
                    else               state_d[i] = S_SYNC_CHECK;
                end
                S_SYNC_EXEC, S_SYNC_WAIT: begin
                    if (all_sync) state_d[i] = all_sync_wait ? S_IDLE : S_SYNC_LAUNCH;
                end
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

    always_comb begin
        actor_start = '0;
        sleep_vec   = '0;
        for (int i = 0; i < NUM_ACTORS; i++) begin
            actor_start[i] = (state_q[i] == S_LAUNCH) || (state_q[i] == S_SYNC_LAUNCH);
            sleep_vec[i]   = (state_q[i] == S_SLEEP);
        end
    end

    assign sync_rounds = rounds_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < NUM_ACTORS; i++) state_q[i] <= S_IDLE;
            en_mask_q <= '0;
            hold_q    <= '0;
            rounds_q  <= '0;
            run_q     <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ACTORS; i++) state_q[i] <= state_d[i];
            en_mask_q <= en_mask_d;
            hold_q    <= hold_d;
            rounds_q  <= rounds_d;
            run_q     <= run_d;
        end
    end

endmodule
